// File: rtl/maxnet_sweep_sched_if.sv
// -----------------------------------------------------------------------------
// maxnet_sweep_sched_if
// Handshake and control bundle between the Maxnet sweep scheduler and its
// surroundings (top-level start/finish, PLU, activation/epsilon registers).
//
// Parameters:
//   IDX_W   neuron index width
//   ITER_W  iteration counter width
//
// Signals:
//   start        begin a run (sampled only when the scheduler is idle)
//   plu_done     PLU result ready, one-cycle pulse
//   nz_flag      PLU result non-zero, qualified by plu_done
//   start_plu    one-cycle PLU launch pulse
//   neuron_idx   neuron being processed / written
//   we_a_reg     load external inputs into the activation registers
//   eps_reg_we   load the epsilon register
//   mux_sel      1 = activations from external port, 0 = from PLU
//   we_prim      write PLU result into the shadow slot at neuron_idx
//   commit       copy shadow activations to primary
//   busy         scheduler is not idle
//   finish       one-cycle completion pulse
//   winner_valid run ended with exactly one survivor
//   winner_idx   survivor index (valid with winner_valid)
//   iter_count   sweeps completed in the current or last run
//   err          timeout or watchdog abort
//
// Modports: slave = scheduler side, master = environment side.
// -----------------------------------------------------------------------------
interface maxnet_sweep_sched_if #(
  parameter int IDX_W  = 2,
  parameter int ITER_W = 6
);
  logic              start;
  logic              plu_done;
  logic              nz_flag;
  logic              start_plu;
  logic [IDX_W-1:0]  neuron_idx;
  logic              we_a_reg;
  logic              eps_reg_we;
  logic              mux_sel;
  logic              we_prim;
  logic              commit;
  logic              busy;
  logic              finish;
  logic              winner_valid;
  logic [IDX_W-1:0]  winner_idx;
  logic [ITER_W-1:0] iter_count;
  logic              err;

  modport slave (
    input  start, plu_done, nz_flag,
    output start_plu, neuron_idx, we_a_reg, eps_reg_we, mux_sel, we_prim,
           commit, busy, finish, winner_valid, winner_idx, iter_count, err
  );

  modport master (
    output start, plu_done, nz_flag,
    input  start_plu, neuron_idx, we_a_reg, eps_reg_we, mux_sel, we_prim,
           commit, busy, finish, winner_valid, winner_idx, iter_count, err
  );
endinterface

// File: rtl/maxnet_sweep_sched.sv
// -----------------------------------------------------------------------------
// maxnet_sweep_sched
// Time-multiplexes one shared PLU across NUM_NEURONS Maxnet neurons. Each
// sweep issues one PLU operation per neuron, writes the results into the
// shadow activation slots and then commits them. After every sweep the
// number of non-zero results decides: one survivor -> winner, none -> all
// suppressed, MAX_ITER sweeps reached -> err, otherwise sweep again.
//
// Optional feature (macro MAXNET_PLU_WATCHDOG_EN): a WAIT-state cycle counter
// aborts the run with err=1 (no commit) if the PLU stays silent for
// WD_CYCLES cycles. Without the macro WAIT waits indefinitely.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  maxnet_sweep_sched_if.slave (handshake, strobes and status)
// -----------------------------------------------------------------------------
module maxnet_sweep_sched #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int MAX_ITER    = 32,
  parameter int ITER_W      = 6,
  parameter int WD_CYCLES   = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  maxnet_sweep_sched_if.slave  bus
);

  if (NUM_NEURONS < 2 || (1 << IDX_W) < NUM_NEURONS ||
      MAX_ITER < 1 || (1 << ITER_W) <= MAX_ITER || WD_CYCLES < 1) begin : g_bad_params
    $error("maxnet_sweep_sched: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_EVAL, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_nz_q, last_nz_d;
  logic [1:0]        nz_cnt_q, nz_cnt_d;     // saturates at 2: only 0, 1, >=2 matter
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] iter_inc;
  logic              winner_valid_q, winner_valid_d;
  logic [IDX_W-1:0]  winner_idx_q, winner_idx_d;
  logic              err_q, err_d;

`ifdef MAXNET_PLU_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      last_nz_q      <= '0;
      nz_cnt_q       <= '0;
      iter_q         <= '0;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      err_q          <= 1'b0;
`ifdef MAXNET_PLU_WATCHDOG_EN
      wd_q           <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q        <= state_d;
      idx_q          <= idx_d;
      last_nz_q      <= last_nz_d;
      nz_cnt_q       <= nz_cnt_d;
      iter_q         <= iter_d;
      winner_valid_q <= winner_valid_d;
      winner_idx_q   <= winner_idx_d;
      err_q          <= err_d;
`ifdef MAXNET_PLU_WATCHDOG_EN
      wd_q           <= wd_d;
`endif
    end
  end

  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    last_nz_d      = last_nz_q;
    nz_cnt_d       = nz_cnt_q;
    iter_d         = iter_q;
    winner_valid_d = winner_valid_q;
    winner_idx_d   = winner_idx_q;
    err_d          = err_q;
`ifdef MAXNET_PLU_WATCHDOG_EN
    wd_d           = wd_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d        = S_LOAD;
          iter_d         = '0;
          err_d          = 1'b0;
          winner_valid_d = 1'b0;
          nz_cnt_d       = '0;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef MAXNET_PLU_WATCHDOG_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.plu_done) begin
          if (bus.nz_flag) begin
            nz_cnt_d  = (nz_cnt_q == 2'd2) ? 2'd2 : nz_cnt_q + 2'd1;
            last_nz_d = idx_q;
          end
          state_d = S_WRITE;
        end
`ifdef MAXNET_PLU_WATCHDOG_EN
        else if (wd_q == WD_W'(WD_CYCLES - 1)) begin
          // PLU is silent: abort without committing; iter_count is kept.
          err_d          = 1'b1;
          winner_valid_d = 1'b0;
          state_d        = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_EVAL;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_EVAL: begin
        iter_d = iter_inc;
        if (nz_cnt_q == 2'd1) begin
          winner_valid_d = 1'b1;
          winner_idx_d   = last_nz_q;
          state_d        = S_DONE;
        end else if (nz_cnt_q == 2'd0) begin
          winner_valid_d = 1'b0;
          err_d          = 1'b0;
          state_d        = S_DONE;
        end else if (iter_inc == ITER_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          nz_cnt_d = '0;
          idx_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobes: decoded from the current state only.
  assign bus.we_a_reg     = (state_q == S_LOAD);
  assign bus.eps_reg_we   = (state_q == S_LOAD);
  assign bus.mux_sel      = (state_q == S_LOAD);
  assign bus.we_prim      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.start_plu    = (state_q == S_ISSUE);
  assign bus.commit       = (state_q == S_EVAL);
  assign bus.finish       = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.neuron_idx   = idx_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner_idx   = winner_idx_q;
  assign bus.iter_count   = iter_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_maxnet_sweep_sched.sv
// -----------------------------------------------------------------------------
// tb_maxnet_sweep_sched
// Self-checking bench for maxnet_sweep_sched. A PLU stub answers each
// start_plu with a programmable latency and a per-(sweep, neuron) nz pattern;
// a reference model derives the expected outcome and cycle count directly
// from the pattern. Directed runs cover the named scenarios, followed by
// randomized runs, mid-run reset and the PLU-silent case.
// -----------------------------------------------------------------------------
module tb_maxnet_sweep_sched;
  localparam int N         = 4;
  localparam int IDX_W     = 2;
  localparam int MAX_ITER  = 4;
  localparam int ITER_W    = 3;
  localparam int WD_CYCLES = 10;
  localparam int BUDGET    = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxnet_sweep_sched_if #(.IDX_W(IDX_W), .ITER_W(ITER_W)) bus ();

  maxnet_sweep_sched #(
    .NUM_NEURONS(N), .IDX_W(IDX_W), .MAX_ITER(MAX_ITER),
    .ITER_W(ITER_W), .WD_CYCLES(WD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus shared with the PLU stub.
  bit pat [MAX_ITER][N];
  int stub_l     = 1;
  bit stub_mute  = 0;
  bit stub_stray = 0;

  // Monitor results (written only by the monitor).
  int mon_commits = 0;
  int mon_pulses  = 0;
  int mon_idx     = 0;
  int idx_bad     = 0;
  int fin_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: walk the sweeps applying the decision rules.
  task automatic model(output int sweeps, output bit wv, output int widx, output bit er);
    sweeps = 0; wv = 0; widx = 0; er = 0;
    for (int s = 0; s < MAX_ITER; s++) begin
      int cnt = 0;
      int last = 0;
      for (int i = 0; i < N; i++) if (pat[s][i]) begin cnt++; last = i; end
      sweeps = s + 1;
      if (cnt == 1) begin wv = 1; widx = last; return; end
      if (cnt == 0) return;
      if (sweeps == MAX_ITER) begin er = 1; return; end
    end
  endtask

  // Monitor: counts strobes and checks neuron_idx stepping per launch.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.we_a_reg) begin
        mon_commits = 0; mon_pulses = 0; mon_idx = 0;
      end
      if (bus.start_plu) begin
        if (int'(bus.neuron_idx) != mon_idx) idx_bad++;
        mon_idx = (mon_idx + 1) % N;
        mon_pulses++;
      end
      if (bus.commit) begin
        mon_commits++;
        mon_idx = 0;
      end
      if (bus.finish) fin_cnt++;
    end
  end

  // PLU stub: the ISSUE cycle is followed by stub_l+1 WAIT cycles, the last
  // carrying plu_done, so each neuron costs stub_l+3 cycles. With stub_stray
  // it also pulses plu_done (nz=1) during ISSUE and WRITE.
  initial begin
    bus.plu_done = 1'b0;
    bus.nz_flag  = 1'b0;
    forever begin
      @(negedge clk);
      bus.plu_done = 1'b0;
      bus.nz_flag  = 1'b0;
      if (bus.start_plu && !stub_mute) begin
        int s;
        int idx;
        bit nz;
        s   = mon_commits % MAX_ITER;
        idx = int'(bus.neuron_idx);
        nz  = pat[s][idx];
        if (stub_stray) begin bus.plu_done = 1'b1; bus.nz_flag = 1'b1; end
        @(negedge clk);
        bus.plu_done = 1'b0;
        bus.nz_flag  = 1'b0;
        repeat (stub_l) @(negedge clk);
        bus.plu_done = 1'b1;
        bus.nz_flag  = nz;
        @(negedge clk);
        bus.plu_done = stub_stray;
        bus.nz_flag  = stub_stray;
      end
    end
  end

  // One complete run from start to finish, checked against the model.
  task automatic run_and_check(input string name, input int lat, input bit spam);
    int n;
    int exp_s;
    int exp_widx;
    bit exp_wv;
    bit exp_err;
    model(exp_s, exp_wv, exp_widx, exp_err);
    stub_l = lat;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.finish && n < BUDGET) begin
      if (spam) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({name, " finish"}, bus.finish, 1);
    check({name, " cycles"}, n, 2 + exp_s * (N * (lat + 3) + 1));
    check({name, " winner_valid"}, bus.winner_valid, exp_wv);
    if (exp_wv) check({name, " winner_idx"}, bus.winner_idx, exp_widx);
    check({name, " iter_count"}, bus.iter_count, exp_s);
    check({name, " err"}, bus.err, exp_err);
    check({name, " commits"}, mon_commits, exp_s);
    check({name, " plu_pulses"}, mon_pulses, exp_s * N);
    check({name, " idx_step"}, idx_bad, 0);
    @(negedge clk);
    check({name, " idle_after"}, {bus.busy, bus.finish}, 0);
    check({name, " hold_iter"}, bus.iter_count, exp_s);
  endtask

  task automatic set_sweep(input int s, input bit [N-1:0] v);
    for (int i = 0; i < N; i++) pat[s][i] = v[N-1-i];
  endtask

  task automatic clear_pat();
    for (int s = 0; s < MAX_ITER; s++) set_sweep(s, '0);
  endtask

  task automatic all_outputs_zero(input string tag);
    check(tag, {bus.start_plu, bus.neuron_idx, bus.we_a_reg, bus.eps_reg_we,
                bus.mux_sel, bus.we_prim, bus.commit, bus.busy, bus.finish,
                bus.winner_valid, bus.winner_idx, bus.iter_count, bus.err}, 0);
  endtask

  initial begin
    int n;
    int fin_before;
    bus.start = 1'b0;
    clear_pat();

    // Reset state.
    #12;
    all_outputs_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    all_outputs_zero("post_reset_idle");

    // Single-sweep winner, L=2: 23 cycles.
    set_sweep(0, 4'b0100);
    run_and_check("single", 2, 0);

    // Multi-sweep convergence to neuron 2.
    clear_pat();
    set_sweep(0, 4'b1111); set_sweep(1, 4'b1010); set_sweep(2, 4'b0010);
    run_and_check("multi", 1, 0);

    // All suppressed in the first sweep.
    clear_pat();
    run_and_check("suppressed", 1, 0);

    // Timeout: never converges.
    for (int s = 0; s < MAX_ITER; s++) set_sweep(s, 4'b1111);
    run_and_check("timeout", 1, 0);

    // Start pulsed repeatedly while busy.
    clear_pat();
    set_sweep(0, 4'b1011); set_sweep(1, 4'b0001);
    run_and_check("start_spam", 3, 1);

    // Stray plu_done in ISSUE and WRITE.
    stub_stray = 1;
    clear_pat();
    set_sweep(0, 4'b1111); set_sweep(1, 4'b1010); set_sweep(2, 4'b0010);
    run_and_check("stray", 2, 0);
    stub_stray = 0;

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < MAX_ITER; s++) set_sweep(s, 4'($urandom_range(0, 15)));
      stub_stray = 1'($urandom_range(0, 1));
      run_and_check($sformatf("rand%0d", r), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
    stub_stray = 0;

    // Reset during WAIT of sweep 2.
    for (int s = 0; s < MAX_ITER; s++) set_sweep(s, 4'b1111);
    stub_l = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.start_plu && mon_commits == 1) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_sweep2", n < BUDGET, 1);
    @(negedge clk);
    check("rst_in_wait_busy", {bus.busy, bus.iter_count}, {1'b1, 3'd1});
    fin_before = fin_cnt;
    #2 rst = 1'b0;
    #1 all_outputs_zero("rst_abort_outputs");
    repeat (6) @(negedge clk);
    all_outputs_zero("rst_held_outputs");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_finish", fin_cnt, fin_before);
    clear_pat();
    set_sweep(0, 4'b0100);
    run_and_check("after_rst", 2, 0);

    // PLU never answers.
    stub_mute = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.start_plu && n < 20) begin @(negedge clk); n++; end
    check("silent_issue_seen", bus.start_plu, 1);
    fin_before = fin_cnt;
    @(negedge clk);
`ifdef MAXNET_PLU_WATCHDOG_EN
    n = 0;
    while (!bus.finish && n < 200) begin @(negedge clk); n++; end
    check("wd_finish", bus.finish, 1);
    check("wd_cycles", n, WD_CYCLES);
    check("wd_err", bus.err, 1);
    check("wd_winner_valid", bus.winner_valid, 0);
    check("wd_no_commit", mon_commits, 0);
    check("wd_iter_kept", bus.iter_count, 0);
`else
    repeat (40) @(negedge clk);
    check("hang_busy", bus.busy, 1);
    check("hang_no_finish", fin_cnt, fin_before);
    check("hang_no_commit", mon_commits, 0);
    rst = 1'b0;
    #1 all_outputs_zero("hang_rst_outputs");
    @(negedge clk);
    rst = 1'b1;
`endif
    stub_mute = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if anything above stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/maxnet_sweep_sched.md
Name: maxnet_sweep_sched

Overview:
- Sequences one shared PLU (processing lane unit) across all NUM_NEURONS Maxnet neurons.
- Each iteration is one sweep: one PLU operation per neuron, then a commit of the new activations.
- After each sweep the block checks convergence (exactly one non-zero activation) or iteration exhaustion.
- Sits between the top-level start/finish handshake and the activation registers, epsilon register, input mux and PLU.

Parameters:
- NUM_NEURONS, 4, number of neurons swept per iteration (≥2).
- IDX_W, 2, width of neuron index; ≥ clog2(NUM_NEURONS).
- MAX_ITER, 32, maximum sweeps before forced finish.
- ITER_W, 6, iteration counter width; ≥ clog2(MAX_ITER+1).
- WD_CYCLES, 63, PLU watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- plu_done  in  1  PLU result ready for the current neuron; one-cycle pulse.
- nz_flag  in  1  PLU result non-zero; valid in the same cycle as plu_done.
- start_plu  out  1  one-cycle PLU launch pulse.
- neuron_idx  out  IDX_W  neuron the PLU is working on / being written.
- we_a_reg  out  1  load external inputs into the activation registers.
- eps_reg_we  out  1  load the epsilon register.
- mux_sel  out  1  1 = activation inputs come from the external port; 0 = from the PLU.
- we_prim  out  1  write the PLU result into the shadow activation slot at neuron_idx.
- commit  out  1  copy shadow activations to primary (end of sweep).
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle completion pulse.
- winner_valid  out  1  the run ended with exactly one survivor.
- winner_idx  out  IDX_W  survivor index; meaningful only when winner_valid=1.
- iter_count  out  ITER_W  sweeps completed in the current or last run.
- err  out  1  timeout or watchdog abort.

Behaviour:
- States: IDLE, LOAD, ISSUE, WAIT, WRITE, EVAL, DONE. State, counters and status are registered. Strobes are decoded from the current state only (Moore).
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0: neuron_idx, iter_count, winner_idx, winner_valid and err cleared.
- IDLE: start=1 → LOAD; on entry to LOAD, clear iter_count, err, winner_valid and the nz counter.
- LOAD (1 cycle): we_a_reg=1, eps_reg_we=1, mux_sel=1, we_prim=1 (primary and shadow both loaded). Then neuron_idx=0 → ISSUE.
- ISSUE (1 cycle): start_plu=1 → WAIT.
- WAIT: hold until plu_done=1.
  - Capture nz_flag into the sweep's nz count; record neuron_idx as last_nz if nz_flag=1.
  - Then → WRITE.
  - A plu_done arriving in any state other than WAIT is ignored.
- WRITE (1 cycle): we_prim=1.
  - If neuron_idx==NUM_NEURONS-1 → EVAL.
  - Else neuron_idx+1 → ISSUE.
- EVAL (1 cycle): commit=1; iter_count+1 (saturates at MAX_ITER). Decision, in priority order:
  1. nz count==1 → winner_valid=1, winner_idx=last_nz, → DONE.
  2. nz count==0 → winner_valid=0, err=0 (all suppressed), → DONE.
  3. iter_count+1==MAX_ITER → err=1, → DONE.
  4. Otherwise clear the nz count, neuron_idx=0, → ISSUE.
- DONE (1 cycle): finish=1 → IDLE. winner_valid, winner_idx, iter_count and err hold until the next start.
- The nz counter saturates at 2; only the values 0, 1 and ≥2 matter.
- Per-neuron cost: 3 + L cycles, where L = cycles from start_plu to plu_done (L≥1).
- A start asserted while busy is ignored, with no effect on any state.
- Asserting rst mid-run aborts immediately to IDLE with all outputs 0. No finish is produced.

Optional Feature:
- Macro: MAXNET_PLU_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on every ISSUE.
  - If it reaches WD_CYCLES without plu_done, go to DONE with err=1, winner_valid=0 and no commit. iter_count keeps its value.
- Undefined: no counter is instantiated; WAIT waits indefinitely for plu_done, and WD_CYCLES is unused.

Test Plan:
- Single-sweep winner: NUM_NEURONS=4, PLU stub L=2, nz_flag per neuron 0,1,0,0.
  - finish occurs 2 + 4·5 + 1 = 23 cycles after start is sampled.
  - winner_valid=1, winner_idx=1, iter_count=1, exactly one commit.
- Multi-sweep convergence: nz patterns per sweep {1,1,1,1}, {1,0,1,0}, {0,0,1,0}.
  - Expect three commits, iter_count=3, winner_idx=2.
  - Expect four start_plu pulses per sweep, with neuron_idx stepping 0..3.
- All suppressed: a sweep returns nz_flag=0 for every neuron → finish, winner_valid=0, err=0, iter_count=1.
- Timeout: MAX_ITER=4, every neuron always non-zero → finish after the 4th EVAL, err=1, iter_count=4, winner_valid=0.
- Reset and start robustness:
  - Pulse start repeatedly during WAIT: ignored.
  - Drop rst during WAIT of sweep 2: all outputs 0 in the same cycle, no finish, and a fresh start afterwards runs normally.
  - A stray plu_done during ISSUE or WRITE is ignored.
- Watchdog (macro defined, WD_CYCLES=10): PLU never responds → finish 10 cycles after WAIT entry, err=1, no commit. With the macro undefined the block stays in WAIT with busy=1.
